// File: rtl/mux2x1_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux2x1_rr_arbiter
// Description : Round-robin arbiter in front of a 2:1 data mux, with a
//               one-entry registered output stage (valid/ready handshake).
//               Optional grant counters are built when MUX_ARB_GRANT_CNT_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module mux2x1_rr_arbiter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] i0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [WIDTH-1:0] i1,
  output logic             gnt1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             sel,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_prio;
  logic             r_sel;
  logic [WIDTH-1:0] r_out;
  logic             w_load;
  logic             w_winner;

  // A slot opens when the stage is empty or is being drained this edge.
  assign w_load   = ~rst & ((r_state == EMPTY) | out_ready) & (req0 | req1);
  assign w_winner = (req0 & req1) ? r_prio : req1;

  assign gnt0 = w_load & ~w_winner;
  assign gnt1 = w_load &  w_winner;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_load) begin
      w_state_nxt = FULL;
    end else if ((r_state == FULL) && out_ready) begin
      w_state_nxt = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out  <= '0;
      r_sel  <= 1'b0;
      r_prio <= 1'b0;
    end else if (w_load) begin
      r_out  <= w_winner ? i1 : i0;
      r_sel  <= w_winner;
      r_prio <= ~w_winner;
    end
  end

  assign out_valid = (r_state == FULL);
  assign out       = r_out;
  assign sel       = r_sel;

`ifdef MUX_ARB_GRANT_CNT_EN
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  // Saturating counters: hold at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (gnt0 && (r_cnt0 != '1)) r_cnt0 <= r_cnt0 + CNT_W'(1);
      if (gnt1 && (r_cnt1 != '1)) r_cnt1 <= r_cnt1 + CNT_W'(1);
    end
  end

  assign grant_cnt0 = r_cnt0;
  assign grant_cnt1 = r_cnt1;
`else
  assign grant_cnt0 = '0;
  assign grant_cnt1 = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux2x1_rr_arbiter.sv
`default_nettype none
// Testbench for mux2x1_rr_arbiter: directed vector table, grant-counter
// saturation sequence, and a randomized scoreboard run.
module tb_mux2x1_rr_arbiter;

  localparam int WIDTH = 4;
  localparam int CNT_W = 2;
`ifdef MUX_ARB_GRANT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req0 = 1'b0, req1 = 1'b0;
  logic [WIDTH-1:0] i0 = '0, i1 = '0;
  logic             gnt0, gnt1;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out;
  logic             sel;
  logic [CNT_W-1:0] grant_cnt0, grant_cnt1;

  int tests = 0;
  int fails = 0;

  mux2x1_rr_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .i0(i0), .gnt0(gnt0),
    .req1(req1), .i1(i1), .gnt1(gnt1),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .sel(sel),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic             rst;
    logic             r0;
    logic [WIDTH-1:0] d0;
    logic             r1;
    logic [WIDTH-1:0] d1;
    logic             rdy;
    logic             g0;
    logic             g1;
    logic             v;
    logic [WIDTH-1:0] o;
    logic             s;
  } vec_t;

  vec_t vecs[16];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             s;
  } item_t;

  item_t sb[$];

  initial begin
    logic [CNT_W-1:0] m_cnt0, m_cnt1;
    logic             pg0, pg1;
    item_t            it;

    //          rst r0 d0    r1 d1    rdy g0 g1 v  o     s
    vecs[0]  = '{1, 1, 4'h1, 1, 4'h2, 1, 0, 0, 0, 4'h0, 0};
    vecs[1]  = '{0, 1, 4'h5, 0, 4'h0, 1, 1, 0, 1, 4'h5, 0};
    vecs[2]  = '{1, 0, 4'h0, 0, 4'h0, 1, 0, 0, 0, 4'h0, 0};
    vecs[3]  = '{0, 1, 4'hA, 1, 4'h3, 1, 1, 0, 1, 4'hA, 0};
    vecs[4]  = '{0, 1, 4'hA, 1, 4'h3, 1, 0, 1, 1, 4'h3, 1};
    vecs[5]  = '{0, 1, 4'hA, 1, 4'h3, 1, 1, 0, 1, 4'hA, 0};
    vecs[6]  = '{0, 1, 4'hA, 1, 4'h3, 1, 0, 1, 1, 4'h3, 1};
    vecs[7]  = '{0, 0, 4'h0, 1, 4'h7, 0, 0, 0, 1, 4'h3, 1};
    vecs[8]  = '{0, 0, 4'h0, 1, 4'h7, 0, 0, 0, 1, 4'h3, 1};
    vecs[9]  = '{0, 0, 4'h0, 1, 4'h7, 0, 0, 0, 1, 4'h3, 1};
    vecs[10] = '{0, 0, 4'h0, 1, 4'h7, 1, 0, 1, 1, 4'h7, 1};
    vecs[11] = '{0, 0, 4'h0, 0, 4'h0, 1, 0, 0, 0, 4'h7, 1};
    vecs[12] = '{0, 1, 4'h2, 0, 4'h0, 0, 1, 0, 1, 4'h2, 0};
    vecs[13] = '{0, 1, 4'h9, 0, 4'h0, 0, 0, 0, 1, 4'h2, 0};
    vecs[14] = '{0, 1, 4'h9, 0, 4'h0, 1, 1, 0, 1, 4'h9, 0};
    vecs[15] = '{1, 0, 4'h0, 1, 4'h6, 1, 0, 0, 0, 4'h0, 0};

    m_cnt0 = '0;
    m_cnt1 = '0;

    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      rst = vecs[k].rst; req0 = vecs[k].r0; i0 = vecs[k].d0;
      req1 = vecs[k].r1; i1 = vecs[k].d1; out_ready = vecs[k].rdy;
      #1;
      check($sformatf("v%0d gnt0", k), 32'(gnt0), 32'(vecs[k].g0));
      check($sformatf("v%0d gnt1", k), 32'(gnt1), 32'(vecs[k].g1));
      if (vecs[k].rst) begin
        m_cnt0 = '0;
        m_cnt1 = '0;
      end else if (CNT_EN) begin
        if (vecs[k].g0) m_cnt0 = sat_inc(m_cnt0);
        if (vecs[k].g1) m_cnt1 = sat_inc(m_cnt1);
      end
      @(posedge clk);
      #1;
      check($sformatf("v%0d out_valid", k), 32'(out_valid), 32'(vecs[k].v));
      check($sformatf("v%0d out", k), 32'(out), 32'(vecs[k].o));
      check($sformatf("v%0d sel", k), 32'(sel), 32'(vecs[k].s));
      check($sformatf("v%0d grant_cnt0", k), 32'(grant_cnt0), 32'(m_cnt0));
      check($sformatf("v%0d grant_cnt1", k), 32'(grant_cnt1), 32'(m_cnt1));
    end

    // Five lone grants to requester 0: counter saturates at 3 for CNT_W=2.
    @(negedge clk);
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; req0 = 1'b1; i0 = 4'h4;
    repeat (5) @(negedge clk);
    req0 = 1'b0;
    #1;
    check("sat grant_cnt0", 32'(grant_cnt0), CNT_EN ? 32'd3 : 32'd0);
    check("sat grant_cnt1", 32'(grant_cnt1), 32'd0);

    // Randomized stress with an in-order scoreboard.
    pg0 = 1'b0;
    pg1 = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    for (int c = 0; c < 1000 + 4; c++) begin
      @(negedge clk);
      if (c < 1000) begin
        if (!req0 || pg0) begin req0 = 1'($urandom_range(0, 1)); i0 = WIDTH'($urandom); end
        if (!req1 || pg1) begin req1 = 1'($urandom_range(0, 1)); i1 = WIDTH'($urandom); end
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        req0 = 1'b0; req1 = 1'b0; out_ready = 1'b1;
      end
      #1;
      check("gnt exclusive", 32'(gnt0 & gnt1), 32'd0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb unexpected item", 32'(out), 32'hFFFF_FFFF);
        end else begin
          it = sb.pop_front();
          check("sb out", 32'(out), 32'(it.d));
          check("sb sel", 32'(sel), 32'(it.s));
        end
      end
      if (gnt0) sb.push_back('{i0, 1'b0});
      if (gnt1) sb.push_back('{i1, 1'b1});
      pg0 = gnt0;
      pg1 = gnt1;
      @(posedge clk);
    end
    #1;
    check("sb drained", 32'(sb.size()), 32'd0);
    check("final out_valid", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mux2x1_rr_arbiter.md
# mux2x1_rr_arbiter

Round-robin arbiter that shares the 2:1 data mux between two requesters and presents the winner through a one-entry registered output stage with a valid/ready handshake. It sequences the mux select from live requests instead of an externally driven `sel`, and sits between two producer agents and a single downstream consumer in the mux test environment.

## Interface
- `WIDTH`, default 4: data width of each requester and of the output.
- `CNT_W`, default 8: width of the per-requester grant counters (see Configuration).

- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `req0`  input  1  requester 0 has data on `i0`; held until `gnt0`.
- `i0`  input  WIDTH  requester 0 data.
- `gnt0`  output  1  combinational; `i0` is captured at this clock edge.
- `req1`  input  1  requester 1 has data on `i1`; held until `gnt1`.
- `i1`  input  WIDTH  requester 1 data.
- `gnt1`  output  1  combinational; `i1` is captured at this clock edge.
- `out_valid`  output  1  registered; `out` holds an unconsumed item.
- `out_ready`  input  1  consumer accepts `out` when both are high.
- `out`  output  WIDTH  registered data of the held item.
- `sel`  output  1  registered; source of the held item (0 = `i0`, 1 = `i1`).
- `grant_cnt0`  output  CNT_W  number of grants issued to requester 0.
- `grant_cnt1`  output  CNT_W  number of grants issued to requester 1.

## Operation
- State machine with 2 states, encoded by `out_valid`:
  - EMPTY: `out_valid`=0.
  - FULL: `out_valid`=1.
- `load` = (EMPTY or `out_ready`) and (`req0` or `req1`).
- Winner selection when `load`:
  - Only one request active: that requester wins.
  - Both active: the requester indicated by the internal priority pointer `prio` wins.
- `gnt0`/`gnt1` = `load` and winner == 0/1. The two grants are never high together.
- On a `load` edge:
  - `out` <= winner's data.
  - `sel` <= winner.
  - `out_valid` <= 1.
  - `prio` <= ~winner.
- On a FULL edge with `out_ready`=1 and no requests: `out_valid` <= 0. `out` and `sel` hold their last values.
- On a FULL edge with `out_ready`=0: everything holds and no grant is issued. Requests stay pending (backpressure).
- Transitions:
  - EMPTY→FULL on `load`.
  - FULL→FULL on `load`, or when `out_ready`=0.
  - FULL→EMPTY on `out_ready`=1 with no requests.
- Requester rule: `req` and data stay stable from assertion until the cycle its `gnt` is high. Dropping `req` early is permitted and simply withdraws the request.

## Timing
- Reset values: `out_valid`=0, `out`=0, `sel`=0, `prio`=0, `grant_cnt0`=0, `grant_cnt1`=0. `gnt0` and `gnt1` are 0 while `rst`=1.
- Reset mid-operation discards any held item; no grant is issued in a reset cycle.
- Latency: data is granted at edge N and is visible on `out` with `out_valid`=1 after edge N.
- Throughput is one item per cycle when `out_ready` stays high (simultaneous drain and reload).
- With both requesters asserting continuously, grants strictly alternate, starting with requester 0 after reset.
- A lone requester is granted every cycle regardless of `prio`; `prio` still toggles to the other requester.

## Configuration
- `MUX_ARB_GRANT_CNT_EN` defined:
  - `grant_cntX` increments on each edge where `gntX`=1.
  - Counters saturate at 2^CNT_W−1 and do not wrap.
  - Counters clear on `rst`.
- Not defined: no counter logic is built, and `grant_cnt0`/`grant_cnt1` are tied to 0.
- Ports are present in both cases.

## Test plan
- Reset, then hold `req0`=1, `i0`=4'h5, `out_ready`=1 for one cycle: `gnt0`=1 in that cycle; next cycle `out`=5, `sel`=0, `out_valid`=1.
- `req0`=`req1`=1 continuously with `i0`=4'hA, `i1`=4'h3, `out_ready`=1: `sel` sequence 0,1,0,1; `out` sequence A,3,A,3.
- FULL with `out_ready`=0 for 3 cycles while `req1`=1: `gnt1`=0 and `out` stable for all 3 cycles. When `out_ready` rises, `gnt1`=1 in that same cycle.
- FULL, `out_ready`=1, no requests: `out_valid`=0 next cycle and `out` keeps its value. Assert `rst` while FULL: `out_valid`=0, `out`=0, `sel`=0 next cycle.
- With `MUX_ARB_GRANT_CNT_EN` defined and `CNT_W`=2, grant `req0` 5 times: `grant_cnt0`=3 (saturated) and `grant_cnt1`=0. Without the macro, both counters read 0.
- Random req/ready stress over 1000 cycles: scoreboard checks each granted item appears on `out` exactly once, in grant order, with the correct `sel`. Also check `gnt0`&`gnt1` is never 1.
